// File: rtl/imem_responder.sv
// Instruction-memory responder between fetch and decode: answers word-address requests
// after WAIT_CYCLES wait states, drops in-flight work on flush, and has a program-load write port.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic [1:0]  dbg_state
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    // Handshakes: a request transfers on an edge with req_valid && req_ready; a response
    // transfers on an edge with rsp_valid && rsp_ready && !flush. Outputs hold while not consumed.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      rsp_instr_q, rsp_addr_q;
    logic             rsp_err_q;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept, load, look_err;
    logic [31:0]      look_addr, look_data;

    // The unsigned offset compare also rejects addresses below BASE_ADDR (they wrap high).
    function automatic logic addr_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a[1:0] != 2'b00) || ({1'b0, off} >= LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    assign accept    = req_valid && req_ready;
    assign look_addr = (state_q == S_WAIT) ? addr_q : req_addr;
    assign look_err  = addr_bad(look_addr);
    assign look_data = mem[addr_idx(look_addr)];
    // With no wait states the response is registered straight from the request on the accept edge.
    assign load = (state_q == S_WAIT && cnt_q == '0 && !flush) || (accept && WAIT_CYCLES == 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rsp_instr_q <= '0;
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (load) begin
                rsp_addr_q  <= look_addr;
                rsp_err_q   <= look_err;
                rsp_instr_q <= look_err ? NOP : look_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_RESP: begin
                    if (state_q == S_RESP && rsp_ready) state_d = S_IDLE;
                    if (accept) begin
                        addr_d = req_addr;
                        if (WAIT_CYCLES == 0) begin
                            state_d = S_RESP;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) state_d = S_RESP;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = !flush && (state_q == S_IDLE || (state_q == S_RESP && rsp_ready));
        rsp_valid = (state_q == S_RESP);
        rsp_instr = rsp_instr_q;
        rsp_addr  = rsp_addr_q;
        rsp_err   = rsp_err_q;
        dbg_state = state_q;
    end

    // Program contents survive reset; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en && !addr_bad(wr_addr)) mem[addr_idx(wr_addr)] <= wr_data;
    end
endmodule
